// File: rtl/load_store_unit_pkg.sv
// Shared ALU operation codes, LSU state encodings and memory-op decode helpers.
// Imported by the load/store unit and its load-alignment sub-module.
package load_store_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [5:0] ALU_NOP = 6'd0;
  localparam logic [5:0] ALU_ADD = 6'd1;
  localparam logic [5:0] ALU_SUB = 6'd2;
  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  localparam int LSU_TIMEOUT = 255;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  function automatic logic is_load(input logic [5:0] op);
    is_load = (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
              (op == ALU_LBU) || (op == ALU_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    is_store = (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    is_mem_op = is_load(op) || is_store(op);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] ofs);
    case (op)
      ALU_LH, ALU_LHU, ALU_SH: is_misaligned = ofs[0];
      ALU_LW, ALU_SW:          is_misaligned = (ofs != 2'b00);
      default:                 is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
// Purely combinational; no backpressure.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [5:0]  alucode,
  input  logic [1:0]  ofs,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (ofs)
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
    endcase
    // halfword accesses are only ever 2-byte aligned by the time data returns
    lane_h = ofs[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (alucode)
      ALU_LB:  load_ext = {{24{lane_b[7]}}, lane_b};
      ALU_LBU: load_ext = {24'h0, lane_b};
      ALU_LH:  load_ext = {{16{lane_h[15]}}, lane_h};
      ALU_LHU: load_ext = {16'h0, lane_h};
      ALU_LW:  load_ext = mem_rdata;
      default: load_ext = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding data-memory access stage: byte-lane stores, extended loads, misalign/timeout errors.
// Latency: misaligned 1 cycle, aligned >= 3 cycles; req_ready is low for the whole access.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] load_data,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [1:0]       ofs_q, ofs_d;
  logic             st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      load_data_q, load_data_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      load_ext;

  lsu_load_align u_load_align (
    .alucode   (op_q),
    .ofs       (ofs_q),
    .mem_rdata (mem_rdata),
    .load_ext  (load_ext)
  );

  assign req_ready  = (state_q == LSU_IDLE) & ~rst;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign load_data  = load_data_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ofs_d        = ofs_q;
    st_d         = st_q;
    cnt_d        = cnt_q;
    resp_valid_d = DISABLE;
    resp_err_d   = resp_err_q;
    load_data_d  = load_data_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      LSU_IDLE: begin
        // non-memory opcodes fall through untouched
        if (req_valid && req_ready && is_mem_op(alucode)) begin
          op_d        = alucode;
          ofs_d       = addr[1:0];
          st_d        = is_store(alucode);
          load_data_d = '0;
          if (is_misaligned(alucode, addr[1:0])) begin
            state_d      = LSU_RESP;
            resp_valid_d = ENABLE;
            resp_err_d   = ENABLE;
          end else begin
            state_d    = LSU_REQ;
            resp_err_d = DISABLE;
            mem_req_d  = ENABLE;
            mem_we_d   = is_store(alucode);
            mem_addr_d = {addr[31:2], 2'b00};
            case (alucode)
              ALU_SB: begin
                mem_be_d    = 4'b0001 << addr[1:0];
                mem_wdata_d = {4{store_data[7:0]}};
              end
              ALU_SH: begin
                mem_be_d    = addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata_d = {2{store_data[15:0]}};
              end
              ALU_SW: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = store_data;
              end
              default: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = '0;
              end
            endcase
          end
        end
      end
      LSU_REQ: begin
        if (mem_gnt) begin
          state_d   = LSU_WAIT;
          mem_req_d = DISABLE;
          cnt_d     = '0;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // an ack arriving on the limit cycle still completes normally
        if (mem_ack) begin
          state_d      = LSU_RESP;
          resp_valid_d = ENABLE;
          resp_err_d   = DISABLE;
          load_data_d  = st_q ? '0 : load_ext;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d      = LSU_RESP;
          resp_valid_d = ENABLE;
          resp_err_d   = ENABLE;
          load_data_d  = '0;
        end
      end
      LSU_RESP: begin
        state_d     = LSU_IDLE;
        resp_err_d  = DISABLE;
        load_data_d = '0;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LSU_IDLE;
      op_q         <= '0;
      ofs_q        <= '0;
      st_q         <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_data_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ofs_q        <= ofs_d;
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      load_data_q  <= load_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment, timeout, reset and idle behaviour.
// Timeout shortened to 4 cycles so the abandon path is reachable quickly.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  alucode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int vectors;
  int miscompares;

  // results of the most recent bus_access call
  logic        b_saw_req;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;
  logic        b_we;
  logic        b_resp;
  logic        b_err;
  logic [31:0] b_data;
  int          b_lat;
  int          b_waits;

  load_store_unit #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .alucode    (alucode),
    .addr       (addr),
    .store_data (store_data),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request in cycle 0 and plays a memory that grants on first sight of
  // mem_req and acks in the following cycle (unless no_ack). b_lat is the cycle of resp_valid.
  task automatic bus_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input logic no_ack);
    b_saw_req = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0; b_we = 1'b0;
    b_resp = 1'b0; b_err = 1'b0; b_data = '0; b_lat = 0; b_waits = 0;
    @(negedge clk);
    req_valid = 1'b1; alucode = op; addr = a; store_data = sd;
    @(negedge clk);
    req_valid = 1'b0; alucode = ALU_NOP;
    b_lat = 1;
    for (int i = 0; i < 20 && !b_resp; i++) begin
      mem_gnt = 1'b0;
      mem_ack = 1'b0;
      if (resp_valid) begin
        b_resp = 1'b1; b_err = resp_err; b_data = load_data;
      end else begin
        if (mem_req) begin
          if (!b_saw_req) begin
            b_addr = mem_addr; b_wdata = mem_wdata; b_be = mem_be; b_we = mem_we;
          end
          b_saw_req = 1'b1;
          mem_gnt = 1'b1;
        end else if (b_saw_req) begin
          b_waits++;
          if (!no_ack) begin
            mem_ack = 1'b1; mem_rdata = rd;
          end
        end
        @(negedge clk);
        b_lat++;
      end
    end
    mem_gnt = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({resp_valid, resp_err, mem_req, mem_we, req_ready} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 00000", {resp_valid, resp_err, mem_req, mem_we, req_ready});
    end
    vectors++;
    if ({load_data, mem_addr, mem_wdata, mem_be} !== 100'b0) begin
      miscompares++;
      $display("FAIL reset_data: load_data=%h mem_addr=%h mem_wdata=%h mem_be=%b expected all 0",
               load_data, mem_addr, mem_wdata, mem_be);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_lw();
    bus_access(ALU_LW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0);
    vectors++;
    if (!(b_resp === 1'b1 && b_lat == 3)) begin
      miscompares++;
      $display("FAIL lw_latency: got resp=%b cycle=%0d expected resp=1 cycle=3", b_resp, b_lat);
    end
    vectors++;
    if ({b_saw_req, b_we, b_be, b_addr} !== {1'b1, 1'b0, 4'b1111, 32'h0000_0100}) begin
      miscompares++;
      $display("FAIL lw_bus: got req=%b we=%b be=%b addr=%h expected req=1 we=0 be=1111 addr=00000100",
               b_saw_req, b_we, b_be, b_addr);
    end
    vectors++;
    if ({b_err, b_data} !== {1'b0, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL lw_data: got err=%b data=%h expected err=0 data=deadbeef", b_err, b_data);
    end
    @(negedge clk);
    vectors++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL lw_pulse_end: got resp_valid=%b req_ready=%b expected 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_loads();
    logic [5:0]  ops [6];
    logic [31:0] adr [6];
    logic [31:0] exp [6];
    ops = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LB, ALU_LH};
    adr = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
    exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012, 32'h0000_8012, 32'h0000_0034, 32'h0000_3456};
    for (int i = 0; i < 6; i++) begin
      bus_access(ops[i], adr[i], 32'h0, 32'h8012_3456, 1'b0);
      vectors++;
      if ({b_resp, b_err, b_data} !== {1'b1, 1'b0, exp[i]}) begin
        miscompares++;
        $display("FAIL load_%0d: got resp=%b err=%b data=%h expected 1 0 %h", i, b_resp, b_err, b_data, exp[i]);
      end
      vectors++;
      if ({b_be, b_addr} !== {4'b1111, 32'h0000_0100}) begin
        miscompares++;
        $display("FAIL load_bus_%0d: got be=%b addr=%h expected 1111 00000100", i, b_be, b_addr);
      end
    end
  endtask

  task automatic test_stores();
    logic [5:0]  ops [5];
    logic [31:0] adr [5];
    logic [31:0] sd  [5];
    logic [3:0]  ebe [5];
    logic [31:0] ewd [5];
    ops = '{ALU_SB, ALU_SH, ALU_SH, ALU_SW, ALU_SB};
    adr = '{32'h201, 32'h202, 32'h200, 32'h300, 32'h203};
    sd  = '{32'h0000_00A5, 32'h0000_1234, 32'hFFFF_BEEF, 32'hCAFE_F00D, 32'h1234_567E};
    ebe = '{4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1000};
    ewd = '{32'hA5A5_A5A5, 32'h1234_1234, 32'hBEEF_BEEF, 32'hCAFE_F00D, 32'h7E7E_7E7E};
    for (int i = 0; i < 5; i++) begin
      bus_access(ops[i], adr[i], sd[i], 32'hFFFF_FFFF, 1'b0);
      vectors++;
      if ({b_we, b_be, b_wdata} !== {1'b1, ebe[i], ewd[i]}) begin
        miscompares++;
        $display("FAIL store_%0d: got we=%b be=%b wdata=%h expected 1 %b %h", i, b_we, b_be, b_wdata, ebe[i], ewd[i]);
      end
      vectors++;
      if ({b_addr, b_resp, b_err, b_data} !== {adr[i] & 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0}) begin
        miscompares++;
        $display("FAIL store_resp_%0d: got addr=%h resp=%b err=%b data=%h expected addr=%h 1 0 00000000",
                 i, b_addr, b_resp, b_err, b_data, adr[i] & 32'hFFFF_FFFC);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [5:0]  ops [4];
    logic [31:0] adr [4];
    ops = '{ALU_SW, ALU_LHU, ALU_LW, ALU_SH};
    adr = '{32'h302, 32'h301, 32'h101, 32'h203};
    for (int i = 0; i < 4; i++) begin
      bus_access(ops[i], adr[i], 32'h1111_2222, 32'h3333_4444, 1'b0);
      vectors++;
      if (!(b_saw_req === 1'b0 && b_resp === 1'b1 && b_lat == 1 && b_err === 1'b1 && b_data === 32'h0)) begin
        miscompares++;
        $display("FAIL misalign_%0d: got req=%b resp=%b cycle=%0d err=%b data=%h expected 0 1 1 1 00000000",
                 i, b_saw_req, b_resp, b_lat, b_err, b_data);
      end
    end
  endtask

  task automatic test_timeout();
    bus_access(ALU_LW, 32'h0000_0400, 32'h0, 32'h5555_5555, 1'b1);
    vectors++;
    if ({b_resp, b_err, b_data} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL timeout_resp: got resp=%b err=%b data=%h expected 1 1 00000000", b_resp, b_err, b_data);
    end
    vectors++;
    if (!(b_waits == 4 && b_lat == 6)) begin
      miscompares++;
      $display("FAIL timeout_len: got wait_cycles=%0d resp_cycle=%0d expected 4 6", b_waits, b_lat);
    end
  endtask

  task automatic test_back_to_back();
    bus_access(ALU_SW, 32'h0000_0500, 32'h0102_0304, 32'h0, 1'b0);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_busy_in_resp: got req_ready=%b expected 0", req_ready);
    end
    bus_access(ALU_LBU, 32'h0000_0502, 32'h0, 32'hAABB_CCDD, 1'b0);
    vectors++;
    if (!(b_resp === 1'b1 && b_lat == 3 && b_data === 32'h0000_00BB)) begin
      miscompares++;
      $display("FAIL b2b_second: got resp=%b cycle=%0d data=%h expected 1 3 000000bb", b_resp, b_lat, b_data);
    end
  endtask

  task automatic test_non_mem();
    @(negedge clk);
    req_valid = 1'b1; alucode = ALU_ADD; addr = 32'h0000_0600;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 1);
      @(negedge clk);
      vectors++;
      if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL non_mem_%0d: got mem_req=%b resp_valid=%b req_ready=%b expected 0 0 1",
                 i, mem_req, resp_valid, req_ready);
      end
    end
    req_valid = 1'b0; alucode = ALU_NOP; mem_ack = 1'b0;
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    req_valid = 1'b1; alucode = ALU_LW; addr = 32'h0000_0704;
    @(negedge clk);
    req_valid = 1'b0; alucode = ALU_NOP;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0704}) begin
        miscompares++;
        $display("FAIL hold_req_%0d: got mem_req=%b addr=%h expected 1 00000704", i, mem_req, mem_addr);
      end
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({mem_req, resp_valid, req_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_in_wait: got mem_req=%b resp_valid=%b req_ready=%b expected 0 0 0",
               mem_req, resp_valid, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_ready_after: got %b expected 1", req_ready);
    end
    // reset asserted while the request is still on the bus
    @(negedge clk);
    req_valid = 1'b1; alucode = ALU_SW; addr = 32'h0000_0800; store_data = 32'h9;
    @(negedge clk);
    req_valid = 1'b0; alucode = ALU_NOP;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({mem_req, resp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_in_req: got mem_req=%b resp_valid=%b expected 0 0", mem_req, resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      @(negedge clk);
      vectors++;
      if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL rst_quiet_%0d: got mem_req=%b resp_valid=%b req_ready=%b expected 0 0 1",
                 i, mem_req, resp_valid, req_ready);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    alucode = ALU_NOP;
    addr = '0;
    store_data = '0;
    mem_gnt = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;

    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_non_mem();
    test_rst_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage that consumes the ALU's effective address (alu_result) and alucode for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Runs one access at a time on a request/grant/acknowledge data-memory bus with byte enables.
- Returns aligned, sign- or zero-extended load data, or a store-complete pulse, to write-back.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before the access is abandoned with an error.
- CNT_W, 8: counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request from execute stage
- req_ready  out  1  unit idle and able to accept a request
- alucode  in  6  operation code, using the shared ALU_* constants
- addr  in  32  effective byte address (ALU result)
- store_data  in  32  rs2 value for stores
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid: misaligned access or timeout
- load_data  out  32  extended load result, valid with resp_valid
- mem_req  out  1  bus request
- mem_gnt  in  1  bus accepted the request this cycle
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits [1:0] = 00
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  read data valid or write done
- mem_rdata  in  32  read word

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst=1, state = IDLE and all registered outputs are 0: resp_valid, resp_err, load_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wait counter.
- req_ready = (state==IDLE) & ~rst.
- Reset mid-access: the access is abandoned and mem_req drops immediately. No response is produced.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: accept when req_valid & req_ready. Latch alucode, addr[1:0] and the load/store type.
  - Non-memory alucode: ignored. No state change, no response.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to RESP with resp_err=1. No bus activity.
  - Otherwise: go to REQ.
- REQ: mem_req=1 with mem_addr={addr[31:2],2'b00}, mem_we, mem_be and mem_wdata held stable. These values are already driven in the first REQ cycle.
  - On mem_gnt: go to WAIT and clear the counter.
  - REQ has no timeout.
- WAIT: mem_req=0; the counter increments each cycle.
  - mem_ack: capture the extracted load data and go to RESP with err=0.
  - Counter == TIMEOUT_CYCLES-1 with no ack: go to RESP with err=1.
  - mem_ack in the same cycle as the limit: ack wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - load_data = 0 for stores and for errors.
- mem_ack outside WAIT is ignored.
- Latency:
  - Misaligned: accept in cycle 0, resp_valid in cycle 1.
  - Aligned, gnt in the first REQ cycle, ack one cycle later: accept in cycle 0, resp_valid in cycle 3.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{sd[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{sd[15:0]}}.
  - SW: be = 4'b1111, wdata = sd.
- Load lanes: mem_be = 4'b1111. shifted = mem_rdata >> (8*addr[1:0]).
  - LB / LBU: sign- / zero-extend shifted[7:0].
  - LH / LHU: sign- / zero-extend shifted[15:0].
  - LW: mem_rdata.
- Back-to-back: a new request is accepted in the cycle after RESP, once state is IDLE again.

Decomposition:
- Shared define file: existing ALU_LB..ALU_SW codes and ENABLE/DISABLE. Add the LSU state encodings (LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_RESP) and a default for LSU_TIMEOUT.
- One combinational sub-module, lsu_load_align: inputs alucode, addr[1:0], mem_rdata; output extended 32-bit data.
- Store lane/BE generation stays inline.

Test Plan:
- LW, addr=0x100, rdata=0xDEADBEEF, gnt in the first REQ cycle, ack the next cycle -> mem_addr=0x100, be=1111, resp_valid in cycle 3, load_data=0xDEADBEEF, err=0.
- LB addr=0x103 and LBU addr=0x103, rdata=0x80123456 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH addr=0x102 -> 0xFFFF8012.
- SB addr=0x201, sd=0x000000A5 -> mem_we=1, be=0010, wdata=0xA5A5A5A5. SH addr=0x202, sd=0x1234 -> be=1100, wdata=0x12341234.
- SW addr=0x302 -> no mem_req, resp_valid next cycle with err=1. LHU addr=0x301 -> same.
- TIMEOUT_CYCLES=4, LW with gnt but no ack -> resp_valid with err=1, load_data=0, exactly 4 WAIT cycles after grant.
- gnt withheld 3 cycles then rst pulsed in WAIT -> mem_req and resp_valid 0 immediately, req_ready=1 after rst falls. ALU_ADD with req_valid=1 -> no bus activity and no response.
